// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared constants and types for the SPI master controller:
//                command encodings, frame/data widths and the FSM state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5,
        ST_GAP     = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl_if
//  Description : Request/response handshake plus the SPI serial lines of the
//                controller. The controller connects through the slave
//                modport; the requester side uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_ctrl_if;
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_cmd;
    logic [DATA_W-1:0] req_payload;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;

    modport slave (
        input  req_valid, req_cmd, req_payload, MISO,
        output req_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

    modport master (
        output req_valid, req_cmd, req_payload, MISO,
        input  req_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

endinterface
`default_nettype wire

// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_shifter
//  Description : 10-bit parallel-load shift-out register (MSB first) and an
//                8-bit shift-in register fed from MISO (first bit ends in MSB).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic               capture_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               miso_i,
    output logic               msb_o,
    output logic [DATA_W-1:0]  rx_o
);

    logic [FRAME_W-1:0] tx_q;
    logic [DATA_W-1:0]  rx_q;

    // Outgoing frame: load on accept, shift left once per transmitted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else if (load_i) begin
            tx_q <= frame_i;
        end else if (shift_i) begin
            tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
        end
    end

    // Incoming byte: MISO enters at the LSB so the first sample ends in bit 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
        end else if (capture_i) begin
            rx_q <= {rx_q[DATA_W-2:0], miso_i};
        end
    end

    assign msb_o = tx_q[FRAME_W-1];
    assign rx_o  = rx_q;

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : SPI master controller. Accepts one request at a time, sends a
//                10-bit {cmd, payload} frame MSB first under SS_n, and for the
//                read-data command shifts an 8-bit byte back from MISO after
//                RD_LAT idle cycles. SS_n stays high GAP_CYC cycles between
//                frames. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LAT  = 2,   // 0..7
    parameter int GAP_CYC = 3    // 1..16 (4-bit state counter)
)(
    input  logic             clk,
    input  logic             a_rst_n,
    spi_master_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_SELECT  = 3'(ST_SELECT);
    localparam logic [2:0] S_SHIFT   = 3'(ST_SHIFT);
    localparam logic [2:0] S_WAIT    = 3'(ST_WAIT);
    localparam logic [2:0] S_CAPTURE = 3'(ST_CAPTURE);
    localparam logic [2:0] S_HOLD    = 3'(ST_HOLD);
    localparam logic [2:0] S_GAP     = 3'(ST_GAP);

    // Counter value on the final cycle of each multi-cycle state.
    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
    localparam logic [3:0] CAP_LAST   = 4'(DATA_W - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);

    // ------------------------------------------------------------------
    // Reset: assertion is asynchronous, release is re-timed to clk so every
    // flop leaves reset on the same edge.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Two-stage release synchroniser for the asynchronous reset input.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State, counter and command register
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        cmd_q;
    logic              accept;
    logic              tx_msb;
    logic [DATA_W-1:0] rx_byte;

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    // Next-state decode; the counter restarts on every state change and
    // saturates rather than wrapping inside a state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) state_d = S_SELECT;
            end
            S_SELECT: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    if (cmd_q != CMD_RD_DATA) begin
                        state_d = S_HOLD;
                    end else if (RD_LAT == 0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (cnt_q == CAP_LAST) state_d = S_HOLD;
            end
            S_HOLD: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q == 4'hF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // State, counter and latched command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_WR_ADDR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) cmd_q <= bus.req_cmd;
        end
    end

    // ------------------------------------------------------------------
    // Shift datapath. Each MOSI bit is registered on the edge that enters
    // (or stays in) SHIFT; MISO is sampled on every edge whose next state is
    // CAPTURE, so the first sample coincides with the entry into CAPTURE.
    // ------------------------------------------------------------------
    logic shift_en;
    logic capture_en;

    assign shift_en   = (state_d == S_SHIFT);
    assign capture_en = (state_d == S_CAPTURE);

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept),
        .shift_i   (shift_en),
        .capture_i (capture_en),
        .frame_i   ({bus.req_cmd, bus.req_payload}),
        .miso_i    (bus.MISO),
        .msb_o     (tx_msb),
        .rx_o      (rx_byte)
    );

    // ------------------------------------------------------------------
    // Registered outputs, all decoded from the next state.
    // ------------------------------------------------------------------
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Output next-values; the read byte is published on the HOLD->GAP edge.
    always_comb begin
        ss_n_d      = (state_d == S_IDLE) || (state_d == S_GAP);
        mosi_d      = (state_d == S_SHIFT) ? tx_msb : 1'b0;
        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_q == S_HOLD) && (cmd_q == CMD_RD_DATA);
        rsp_data_d  = rsp_valid_d ? rx_byte : rsp_data_q;
    end

    // Output registers with their reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_ctrl
//  Description : Self-checking bench for spi_master_ctrl. Two instances:
//                A (RD_LAT=2, GAP_CYC=3) and B (RD_LAT=0, GAP_CYC=1). The bench
//                plays the SPI slave + RAM as a simple address/data model and
//                predicts every output cycle by cycle from the frame timeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n;
    logic       sel;          // 0 drives/observes instance A, 1 instance B
    logic       drv_valid;
    logic [1:0] drv_cmd;
    logic [7:0] drv_payload;
    logic       drv_miso;

    spi_master_ctrl_if if_a ();
    spi_master_ctrl_if if_b ();

    assign if_a.req_valid   = drv_valid & ~sel;
    assign if_a.req_cmd     = drv_cmd;
    assign if_a.req_payload = drv_payload;
    assign if_a.MISO        = drv_miso;
    assign if_b.req_valid   = drv_valid & sel;
    assign if_b.req_cmd     = drv_cmd;
    assign if_b.req_payload = drv_payload;
    assign if_b.MISO        = drv_miso;

    spi_master_ctrl #(.RD_LAT(2), .GAP_CYC(3)) dut_a (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .bus     (if_a.slave)
    );

    spi_master_ctrl #(.RD_LAT(0), .GAP_CYC(1)) dut_b (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .bus     (if_b.slave)
    );

    logic       obs_ss, obs_mosi, obs_ready, obs_busy, obs_rv;
    logic [7:0] obs_rd;
    assign obs_ss    = sel ? if_b.SS_n      : if_a.SS_n;
    assign obs_mosi  = sel ? if_b.MOSI      : if_a.MOSI;
    assign obs_ready = sel ? if_b.req_ready : if_a.req_ready;
    assign obs_busy  = sel ? if_b.busy      : if_a.busy;
    assign obs_rv    = sel ? if_b.rsp_valid : if_a.rsp_valid;
    assign obs_rd    = sel ? if_b.rsp_data  : if_a.rsp_data;

    int tests = 0;
    int fails = 0;

    // Slave/RAM reference model
    logic [7:0] ram [256];
    logic [7:0] m_addr;
    logic [7:0] m_rd_addr;
    logic [7:0] exp_rsp_a;
    logic [7:0] exp_rsp_b;

    task automatic chk1(input string tag, input int c, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %0b, expected %0b", tag, c, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %02h, expected %02h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rsp();
        return sel ? exp_rsp_b : exp_rsp_a;
    endfunction

    task automatic set_exp_rsp(input logic [7:0] v);
        if (sel) exp_rsp_b = v;
        else     exp_rsp_a = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk1("idle_ss_n", i, obs_ss, 1'b1);
            chk1("idle_mosi", i, obs_mosi, 1'b0);
            chk1("idle_ready", i, obs_ready, 1'b1);
            chk1("idle_busy", i, obs_busy, 1'b0);
            chk1("idle_rsp_valid", i, obs_rv, 1'b0);
            chk8("idle_rsp_data", i, obs_rd, exp_rsp());
            drv_miso = 1'($urandom);
        end
    endtask

    // One complete frame. Starts at a negedge with the controller idle and
    // ends at the negedge after which req_ready is high again. Cycle c means
    // "after accept edge E0 + c".
    task automatic run_frame(input logic [1:0] cmd, input logic [7:0] pay, input bit hold_valid);
        int         rl;
        int         gap;
        bit         rd;
        int         total;
        int         low_end;
        logic [9:0] frame;
        logic [7:0] mb;
        logic [7:0] prev;
        logic       e_mosi;
        rl      = sel ? 0 : 2;
        gap     = sel ? 1 : 3;
        rd      = (cmd == 2'b11);
        frame   = {cmd, pay};
        total   = rd ? (21 + rl + gap) : (13 + gap);
        low_end = rd ? (19 + rl) : 11;
        mb      = ram[m_rd_addr];
        prev    = exp_rsp();

        chk1("pre_ready", -1, obs_ready, 1'b1);
        drv_valid   = 1'b1;
        drv_cmd     = cmd;
        drv_payload = pay;
        @(posedge clk);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (!hold_valid) begin
                    drv_valid = 1'b0;
                end else begin
                    drv_cmd     = 2'($urandom);
                    drv_payload = 8'($urandom);
                end
            end
            e_mosi = (c >= 1 && c <= 10) ? frame[10 - c] : 1'b0;
            chk1("ss_n", c, obs_ss, (c <= low_end) ? 1'b0 : 1'b1);
            chk1("mosi", c, obs_mosi, e_mosi);
            chk1("ready", c, obs_ready, (c == total - 1) ? 1'b1 : 1'b0);
            chk1("busy", c, obs_busy, (c == total - 1) ? 1'b0 : 1'b1);
            chk1("rsp_valid", c, obs_rv, (rd && c == 20 + rl) ? 1'b1 : 1'b0);
            chk8("rsp_data", c, obs_rd, (rd && c >= 20 + rl) ? mb : prev);
            // MISO bit for the sample taken on the following edge
            if (rd && c >= 10 + rl && c <= 17 + rl) drv_miso = mb[7 - (c - 10 - rl)];
            else                                    drv_miso = 1'($urandom);
        end

        case (cmd)
            2'b00:   m_addr = pay;
            2'b01:   ram[m_addr] = pay;
            2'b10:   m_rd_addr = pay;
            default: set_exp_rsp(mb);
        endcase
    endtask

    initial begin
        logic [1:0] rc;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        m_addr      = 8'h00;
        m_rd_addr   = 8'h00;
        exp_rsp_a   = 8'h00;
        exp_rsp_b   = 8'h00;
        sel         = 1'b0;
        drv_valid   = 1'b1;
        drv_cmd     = 2'b11;
        drv_payload = 8'h5A;
        drv_miso    = 1'b1;
        a_rst_n     = 1'b1;
        #2 a_rst_n  = 1'b0;

        // Reset held 3 cycles with a request pending on both instances
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rst_a_ss_n", i, if_a.SS_n, 1'b1);
            chk1("rst_a_mosi", i, if_a.MOSI, 1'b0);
            chk1("rst_a_ready", i, if_a.req_ready, 1'b1);
            chk1("rst_a_busy", i, if_a.busy, 1'b0);
            chk1("rst_a_rsp_valid", i, if_a.rsp_valid, 1'b0);
            chk8("rst_a_rsp_data", i, if_a.rsp_data, 8'h00);
            chk1("rst_b_ss_n", i, if_b.SS_n, 1'b1);
            chk1("rst_b_ready", i, if_b.req_ready, 1'b1);
            chk8("rst_b_rsp_data", i, if_b.rsp_data, 8'h00);
        end
        drv_valid = 1'b0;
        a_rst_n   = 1'b1;
        idle(4);

        // Single write-address frame, payload 0xAC
        run_frame(2'b00, 8'hAC, 1'b0);
        idle(2);

        // Full path: write AC<-EE, then read it back
        run_frame(2'b00, 8'hAC, 1'b0);
        run_frame(2'b01, 8'hEE, 1'b0);
        run_frame(2'b10, 8'hAC, 1'b0);
        run_frame(2'b11, 8'hBC, 1'b0);
        chk8("fullpath_rsp_data", 0, obs_rd, 8'hEE);
        idle(1);

        // Randomized frames with random idle spacing
        for (int i = 0; i < 10; i++) begin
            rc = 2'($urandom_range(0, 3));
            run_frame(rc, 8'($urandom), 1'b0);
            idle($urandom_range(0, 3));
        end

        // req_valid held continuously, commands alternating
        for (int i = 0; i < 6; i++) begin
            run_frame(2'(i % 4), 8'($urandom), 1'b1);
        end
        drv_valid = 1'b0;
        idle(2);

        // Reset at E5 of a read-data frame
        drv_valid   = 1'b1;
        drv_cmd     = 2'b11;
        drv_payload = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk1("midrst_ss_low_before", 4, obs_ss, 1'b0);
        @(posedge clk);
        #1 a_rst_n = 1'b0;
        #1;
        chk1("midrst_ss_n", 5, obs_ss, 1'b1);
        chk1("midrst_mosi", 5, obs_mosi, 1'b0);
        chk1("midrst_ready", 5, obs_ready, 1'b1);
        chk1("midrst_busy", 5, obs_busy, 1'b0);
        chk1("midrst_rsp_valid", 5, obs_rv, 1'b0);
        chk8("midrst_rsp_data", 5, obs_rd, 8'h00);
        exp_rsp_a = 8'h00;
        exp_rsp_b = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("midrst_hold_ss_n", i, obs_ss, 1'b1);
            chk1("midrst_hold_rsp_valid", i, obs_rv, 1'b0);
        end
        a_rst_n = 1'b1;
        idle(30);
        run_frame(2'b11, 8'($urandom), 1'b0);
        idle(2);

        // Instance B: RD_LAT=0, GAP_CYC=1; read returns 0x81
        sel = 1'b1;
        idle(2);
        run_frame(2'b00, 8'h5A, 1'b0);
        run_frame(2'b01, 8'h81, 1'b0);
        run_frame(2'b10, 8'h5A, 1'b0);
        run_frame(2'b11, 8'($urandom), 1'b0);
        chk8("rdlat0_rsp_data", 0, obs_rd, 8'h81);
        for (int i = 0; i < 8; i++) begin
            rc = 2'($urandom_range(0, 3));
            run_frame(rc, 8'($urandom), 1'b0);
            idle($urandom_range(0, 2));
        end
        for (int i = 0; i < 4; i++) begin
            run_frame(2'(3 - i), 8'($urandom), 1'b1);
        end
        drv_valid = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
